seg_scan_controller: RTL and testbench

Time-multiplexed scan controller that shares one BCD-to-7-segment decoder (inputs b3..b0, outputs a..g) across NUM_DIGITS common-cathode digits. It holds a display word loaded over a valid/ready handshake, and steps through the digits one slot at a time. For each slot it presents the digit's BCD nibble and a blank flag to the decoder, and drives a one-hot digit enable. The block sits between the system's numeric source and the shared decoder and digit drivers.

---
 rtl/seg_scan_controller.sv | 164 ++++++++++++++++
 tb/tb_seg_scan_controller.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Scan controller: time-multiplexes one BCD-to-7-segment decoder across
// NUM_DIGITS common-cathode digits, with a blanked guard at each slot start.
module seg_scan_controller #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 1000,
  parameter int unsigned GUARD_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pending_q, pending_d;
  logic                pend_full_q, pend_full_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  logic [NUM_DIGITS-1:0] digit_en_d;
  logic [3:0]            bcd_d;
  logic                  blank_d;
  logic                  frame_done_d;
  logic [3:0]            nib;
  logic                  upper_zero;

  // Ready is a direct decode of the pending-slot flag.
  assign load_ready = ~pend_full_q;

  // Next-state, load handshake and output decode. Outputs are computed from
  // the next-state values so the registered outputs line up with the state.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    pend_full_d  = pend_full_q;
    active_d     = active_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    digit_en_d   = '0;
    bcd_d        = 4'd0;
    blank_d      = 1'b1;
    frame_done_d = 1'b0;
    nib          = 4'd0;
    upper_zero   = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (pend_full_q) begin
          active_d    = pending_q;
          pend_full_d = 1'b0;
          idx_d       = '0;
          cnt_d       = '0;
          state_d     = ST_GUARD;
        end
      end
      ST_GUARD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d   = '0;
          state_d = ST_GUARD;
          if (idx_q == IDX_LAST) begin
            // Frame boundary: only here may a pending word become active.
            idx_d = '0;
            if (pend_full_q) begin
              active_d    = pending_q;
              pend_full_d = 1'b0;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Acceptance needs an empty pending slot, so it never meets a transfer.
    if (load_valid && !pend_full_q) begin
      pending_d   = load_data;
      pend_full_d = 1'b1;
    end

    // Nibble for the upcoming digit and leading-zero scan of digits >= idx.
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib = active_d[4*i +: 4];
      end
      if (IDX_W'(i) >= idx_d && active_d[4*i +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end

    if (state_d != ST_IDLE) begin
      bcd_d = nib;
    end

    if (state_d == ST_SHOW) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i)) begin
          digit_en_d[i] = 1'b1;
        end
      end
      blank_d      = (nib > 4'd9) || (lz_en && (idx_d != '0) && upper_zero);
      frame_done_d = (cnt_d == SLOT_LAST) && (idx_d == IDX_LAST);
    end
  end

  // State, data and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      pend_full_q <= 1'b0;
      active_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      digit_en    <= '0;
      bcd_out     <= 4'd0;
      dec_blank   <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      digit_en    <= digit_en_d;
      bcd_out     <= bcd_d;
      dec_blank   <= blank_d;
      frame_done  <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller (4 digits, 16-cycle slots, 2 guard).
module tb_seg_scan_controller;

  localparam int unsigned ND = 4;
  localparam int unsigned SC = 16;
  localparam int unsigned GC = 2;
  localparam int FRAME = ND * SC;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic          load_ready;
  logic [15:0]   load_data;
  logic          lz_en;
  logic [3:0]    bcd_out;
  logic          dec_blank;
  logic [ND-1:0] digit_en;
  logic          frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  seg_scan_controller #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SC),
    .GUARD_CYCLES(GC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .lz_en     (lz_en),
    .bcd_out   (bcd_out),
    .dec_blank (dec_blank),
    .digit_en  (digit_en),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Hard stop in case stimulus ever stalls.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expects to be called at the negedge of frame offset 'first' (offset 0 is
  // the first guard cycle of digit 0); returns at the negedge of offset last+1.
  // mask bit i = digit i expected blanked during its SHOW cycles.
  task automatic check_frame(input string tag, input logic [15:0] word, input logic lz,
                             input logic [3:0] mask, input int first, input int last);
    int slot;
    int off;
    logic [9:0] exp_v;
    logic [9:0] got_v;
    lz_en = lz;
    for (int c = first; c <= last; c++) begin
      slot = c / SC;
      off  = c % SC;
      exp_v[3:0] = word[4*slot +: 4];
      if (off < GC) begin
        exp_v[7:4] = 4'b0000;
        exp_v[8]   = 1'b1;
      end else begin
        exp_v[7:4] = 4'b0001 << slot;
        exp_v[8]   = mask[slot];
      end
      exp_v[9] = (c == FRAME - 1);
      got_v = {frame_done, dec_blank, digit_en, bcd_out};
      chk($sformatf("%s@%0d", tag, c), 32'(got_v), 32'(exp_v));
      @(negedge clk);
    end
  endtask

  // Idle: no digit lit, blanked, ready, no frame pulse.
  task automatic idle_check(input string tag, input int cycles);
    int bad;
    bad = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (digit_en !== '0 || dec_blank !== 1'b1 || load_ready !== 1'b1 ||
          frame_done !== 1'b0 || bcd_out !== 4'd0) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  // Load from IDLE; returns at the negedge of frame offset 0.
  task automatic load_from_idle(input string tag, input logic [15:0] w);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    load_valid = 1'b0;
    chk({tag, "_ready_low"}, 32'(load_ready), 32'd0);
    chk({tag, "_still_dark"}, 32'(digit_en), 32'd0);
    @(negedge clk);
    chk({tag, "_ready_back"}, 32'(load_ready), 32'd1);
  endtask

  // Called at frame offset 0 while running; returns at offset 0 of the frame
  // that shows w.
  task automatic next_word(input logic [15:0] w);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (FRAME - 1) @(negedge clk);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    lz_en      = 1'b0;
    #1;
    chk("rst_digit_en", 32'(digit_en), 32'd0);
    chk("rst_blank", 32'(dec_blank), 32'd1);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // 1: no load -> stays idle.
    idle_check("idle_no_load", 150);

    // 2: 1234 from idle, two back-to-back frames.
    @(negedge clk);
    load_from_idle("ld1234", 16'h1234);
    check_frame("f1234a", 16'h1234, 1'b0, 4'b0000, 0, FRAME - 1);
    check_frame("f1234b", 16'h1234, 1'b0, 4'b0000, 0, FRAME - 1);

    // 3: leading-zero suppression on 0070.
    next_word(16'h0070);
    check_frame("f0070_lz", 16'h0070, 1'b1, 4'b1100, 0, FRAME - 1);
    check_frame("f0070_nolz", 16'h0070, 1'b0, 4'b0000, 0, FRAME - 1);

    // 4: invalid BCD nibble blanks its digit only.
    next_word(16'h00A5);
    check_frame("f00a5", 16'h00A5, 1'b0, 4'b0010, 0, FRAME - 1);
    check_frame("f00a5_lz", 16'h00A5, 1'b1, 4'b1110, 0, FRAME - 1);

    // 5: double buffering while running 1234.
    next_word(16'h1234);
    check_frame("f1234c", 16'h1234, 1'b0, 4'b0000, 0, 19);
    load_valid = 1'b1;
    load_data  = 16'h5678;
    @(negedge clk);
    chk("pend_ready_low", 32'(load_ready), 32'd0);
    load_data = 16'h9999;
    check_frame("f1234c_tail", 16'h1234, 1'b0, 4'b0000, 21, FRAME - 1);
    chk("boundary_ready", 32'(load_ready), 32'd1);
    check_frame("f5678_head", 16'h5678, 1'b0, 4'b0000, 0, 0);
    load_valid = 1'b0;
    chk("second_taken", 32'(load_ready), 32'd0);
    check_frame("f5678", 16'h5678, 1'b0, 4'b0000, 1, FRAME - 1);
    check_frame("f9999", 16'h9999, 1'b0, 4'b0000, 0, FRAME - 1);

    // 6: reset during SHOW of digit 2 with a word pending.
    check_frame("f9999_pre", 16'h9999, 1'b0, 4'b0000, 0, 39);
    chk("pre_rst_digit2", 32'(digit_en), 32'h4);
    load_valid = 1'b1;
    load_data  = 16'h7777;
    @(negedge clk);
    load_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_digit_en", 32'(digit_en), 32'd0);
    chk("midrst_blank", 32'(dec_blank), 32'd1);
    chk("midrst_bcd", 32'(bcd_out), 32'd0);
    chk("midrst_ready", 32'(load_ready), 32'd1);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check("idle_after_rst", 150);

    // Fresh load after reset runs normally.
    @(negedge clk);
    load_from_idle("ld4321", 16'h4321);
    check_frame("f4321", 16'h4321, 1'b0, 4'b0000, 0, FRAME - 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
